clut_rle_enc: RTL

- CD-i RLE7 line encoder: turns a stream of 7-bit CLUT indices into run-length-coded bytes that clut_rle (ft = kRunLength) decodes back to the identical pixel line.
- Sits on the write-back/capture path, between a pixel source and the display-file memory writer.
- Line length is 360 (st = 1) or 384 (st = 0) pixels; the encoder never carries a run across a line boundary.

---
 rtl/clut_rle_enc_if.sv | 11 +
 rtl/clut_rle_enc.sv | 132 +++++++++++++
 2 files changed

// File: rtl/clut_rle_enc_if.sv
// clut_rle_enc_if: pixel/byte stream with write/strobe handshake.
//   pixel[7:0] : data, driven by the master
//   write      : master has data on pixel
//   strobe     : slave accepts; a transfer happens when write && strobe
interface clut_rle_enc_if;
  logic [7:0] pixel;
  logic       write;
  logic       strobe;
  modport master(output pixel, output write, input strobe);
  modport slave(input pixel, input write, output strobe);
endinterface

// File: rtl/clut_rle_enc.sv
// clut_rle_enc: CD-i RLE7 line encoder, 7-bit CLUT indices in, run-length coded bytes out.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   st      : line length select (1 = 360 px, 0 = 384 px), sampled at line start
//   src     : slave stream of pixels (pixel[6:0] = CLUT index, pixel[7] ignored)
//   dst     : master stream of encoded bytes
//   Macro CLUT_RLE_EOL_CODE_EN: runs ending at end of line emit count 0 ("to end of line").
module clut_rle_enc #(
  parameter int MIN_RUN = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           st,
  clut_rle_enc_if.slave  src,
  clut_rle_enc_if.master dst
);
  typedef enum logic [2:0] {EMPTY, ACCUM, EMIT_CODE, EMIT_COUNT, EMIT_LIT} state_t;
  localparam logic [8:0] MR = 9'(MIN_RUN);
  state_t     state, state_n;
  logic [6:0] run_pix, run_pix_n, pend, pend_n, fl_pix;
  logic [8:0] run_len, run_len_n, linecnt, linecnt_n, cur, chunk, fl_len;
  logic       pend_valid, pend_valid_n, pend_eol, pend_eol_n, eol_flag, eol_n;
  logic [7:0] out_q, out_n;
  logic       acc, last, same, done, do_fl, eol_zero, unused;
  assign unused = src.pixel[7];
  assign src.strobe = reset_n && (state == EMPTY || state == ACCUM);
  assign dst.write = state == EMIT_CODE || state == EMIT_COUNT || state == EMIT_LIT;
  assign dst.pixel = out_q;
  assign acc = src.write && src.strobe;
  // linecnt == 0 marks a line start, so st is sampled on the line's first pixel
  assign cur = (linecnt == 9'd0) ? (st ? 9'd360 : 9'd384) : linecnt;
  assign last = cur == 9'd1;
  assign same = state == EMPTY || src.pixel[6:0] == run_pix;
`ifdef CLUT_RLE_EOL_CODE_EN
  assign eol_zero = eol_flag;
`else
  assign eol_zero = 1'b0;
`endif
  assign chunk = eol_zero ? 9'd0 : (run_len > 9'd255 ? 9'd255 : run_len);
  always_comb begin
    state_n = state;
    run_pix_n = run_pix;
    run_len_n = run_len;
    pend_n = pend;
    pend_valid_n = pend_valid;
    pend_eol_n = pend_eol;
    eol_n = eol_flag;
    out_n = out_q;
    linecnt_n = linecnt;
    done = 1'b0;
    do_fl = 1'b0;
    fl_len = run_len;
    fl_pix = run_pix;
    if (acc) begin
      linecnt_n = cur - 9'd1;
      if (same) begin
        run_pix_n = src.pixel[6:0];
        run_len_n = run_len + 9'd1;
        state_n = ACCUM;
        if (last) begin
          eol_n = 1'b1;
          do_fl = 1'b1;
          fl_len = run_len + 9'd1;
          fl_pix = src.pixel[6:0];
        end
      end else begin
        pend_n = src.pixel[6:0];
        pend_valid_n = 1'b1;
        pend_eol_n = last;
        do_fl = 1'b1;
      end
    end
    if (state == EMIT_CODE && dst.strobe) begin
      state_n = EMIT_COUNT;
      out_n = chunk[7:0];
      run_len_n = eol_zero ? 9'd0 : run_len - chunk;
    end
    // remaining length after a count byte: either finished or another flush round
    if (state == EMIT_COUNT && dst.strobe) begin
      done = run_len == 9'd0;
      do_fl = run_len != 9'd0;
    end
    if (state == EMIT_LIT && dst.strobe) begin
      run_len_n = run_len - 9'd1;
      done = run_len == 9'd1;
    end
    if (done) begin
      eol_n = 1'b0;
      pend_valid_n = 1'b0;
      pend_eol_n = 1'b0;
      run_len_n = {8'd0, pend_valid};
      run_pix_n = pend;
      state_n = pend_valid ? ACCUM : EMPTY;
      // a pending pixel that was the line's last forms its own 1-pixel EOL run
      if (pend_valid && pend_eol) begin
        eol_n = 1'b1;
        do_fl = 1'b1;
        fl_len = 9'd1;
        fl_pix = pend;
      end
    end
    if (do_fl) begin
      run_len_n = fl_len;
      run_pix_n = fl_pix;
      state_n = fl_len >= MR ? EMIT_CODE : EMIT_LIT;
      out_n = {fl_len >= MR, fl_pix};
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      run_pix <= '0;
      run_len <= '0;
      pend <= '0;
      pend_valid <= 1'b0;
      pend_eol <= 1'b0;
      eol_flag <= 1'b0;
      out_q <= '0;
      linecnt <= '0;
    end else begin
      state <= state_n;
      run_pix <= run_pix_n;
      run_len <= run_len_n;
      pend <= pend_n;
      pend_valid <= pend_valid_n;
      pend_eol <= pend_eol_n;
      eol_flag <= eol_n;
      out_q <= out_n;
      linecnt <= linecnt_n;
    end
  end
endmodule
